// File: rtl/sync_fifo_prm_pkg.sv
// rtl/sync_fifo_prm_pkg.sv - shared defaults and width helpers for sync_fifo_prm
package sync_fifo_prm_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;

  function automatic int calc_aw(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int calc_cw(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_dpram.sv
// rtl/fifo_dpram.sv - DEPTH x DATA_W storage, one synchronous write port, one async read port
module fifo_dpram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_prm.sv
// rtl/sync_fifo_prm.sv - synchronous FIFO with threshold flags, sticky errors and optional FWFT read
module sync_fifo_prm
  import sync_fifo_prm_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int DEPTH  = DEF_DEPTH,
  parameter  int FWFT   = 0,
  localparam int AW     = calc_aw(DEPTH),
  localparam int CW     = calc_cw(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic [CW-1:0]     ae_level,
  input  logic [CW-1:0]     af_level,
  input  logic              err_clr,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              empty,
  output logic              a_empty,
  output logic              h_empty,
  output logic              h_full,
  output logic              a_full,
  output logic              full,
  output logic              overflow,
  output logic              underflow,
  output logic [CW-1:0]     count
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] HALF_CNT = CW'(DEPTH / 2);
  localparam logic          IS_FWFT  = (FWFT != 0);

  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [DATA_W-1:0] mem_rdata;
  logic              wr_acc;
  logic              rd_acc;
  logic              ovf_set;
  logic              unf_set;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign a_empty = (count <= ae_level);
  assign a_full  = (count >= af_level);
  assign h_empty = (count < HALF_CNT);
  assign h_full  = (count >= HALF_CNT);

  assign wr_acc  = wr_en & ~full;
  assign rd_acc  = rd_en & ~empty;
  assign ovf_set = wr_en & full;
  // In FWFT mode a read against an empty FIFO being filled on the same edge is not an error
  assign unf_set = rd_en & empty & ~(IS_FWFT & wr_en);

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      overflow  <= ovf_set | (overflow & ~err_clr);
      underflow <= unf_set | (underflow & ~err_clr);
    end
  end

  fifo_dpram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  generate
    if (FWFT == 0) begin : g_reg_read
      logic [DATA_W-1:0] dout_q;
      logic              valid_q;

      always_ff @(posedge clk) begin
        if (!reset) begin
          dout_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= rd_acc;
          if (rd_acc) dout_q <= mem_rdata;
        end
      end

      assign data_out = dout_q;
      assign rd_valid = valid_q;
    end else begin : g_fwft
      assign data_out = mem_rdata;
      assign rd_valid = ~empty;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_prm.sv
// tb/tb_sync_fifo_prm.sv - self-checking bench for sync_fifo_prm (registered and FWFT instances)
module tb_sync_fifo_prm;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [4:0] ae_level = 5'd2;
  logic [4:0] af_level = 5'd14;
  logic       wr_en_b = 1'b0;
  logic       rd_en_b = 1'b0;

  logic [7:0] data_out, data_out_b;
  logic       rd_valid, empty, a_empty, h_empty, h_full, a_full, full, overflow, underflow;
  logic       rd_valid_b, empty_b, a_empty_b, h_empty_b, h_full_b, a_full_b, full_b;
  logic       overflow_b, underflow_b;
  logic [4:0] count, count_b;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_q[$];
  logic [7:0] sb[$];
  logic       m_ovf, m_unf, m_valid;
  logic [7:0] m_dout;

  typedef struct {
    bit         wr;
    bit         rd;
    logic [7:0] din;
    int         cnt;
    bit         full;
    bit         af;
    bit         empty;
    bit         ovf;
    bit         unf;
    logic [7:0] dout;
  } vec_t;

  vec_t vt[34];

  always #5 clk = ~clk;

  sync_fifo_prm #(.DATA_W(8), .DEPTH(16), .FWFT(0)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in),
    .ae_level(ae_level), .af_level(af_level), .err_clr(err_clr),
    .data_out(data_out), .rd_valid(rd_valid), .empty(empty), .a_empty(a_empty),
    .h_empty(h_empty), .h_full(h_full), .a_full(a_full), .full(full),
    .overflow(overflow), .underflow(underflow), .count(count)
  );

  sync_fifo_prm #(.DATA_W(8), .DEPTH(16), .FWFT(1)) dut_b (
    .clk(clk), .reset(reset), .wr_en(wr_en_b), .rd_en(rd_en_b), .data_in(data_in),
    .ae_level(ae_level), .af_level(af_level), .err_clr(err_clr),
    .data_out(data_out_b), .rd_valid(rd_valid_b), .empty(empty_b), .a_empty(a_empty_b),
    .h_empty(h_empty_b), .h_full(h_full_b), .a_full(a_full_b), .full(full_b),
    .overflow(overflow_b), .underflow(underflow_b), .count(count_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock of stimulus on the registered-read instance, with model update and full compare
  task automatic cycle(input bit w, input bit r, input bit c, input bit rs, input logic [7:0] d);
    bit f, e;
    int n;
    wr_en = w; rd_en = r; err_clr = c; reset = rs; data_in = d;
    @(posedge clk);
    if (!rs) begin
      m_q.delete(); sb.delete();
      m_ovf = 0; m_unf = 0; m_dout = 8'h00; m_valid = 0;
    end else begin
      f = (m_q.size() == 16);
      e = (m_q.size() == 0);
      m_valid = 0;
      if (r && !e) begin
        m_dout = m_q.pop_front();
        sb.push_back(m_dout);
        m_valid = 1;
      end
      if (w && !f) m_q.push_back(d);
      m_ovf = (m_ovf && !c) || (w && f);
      m_unf = (m_unf && !c) || (r && e);
    end
    #1;
    n = m_q.size();
    chk("count", 32'(count), 32'(n));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("full", 32'(full), 32'(n == 16));
    chk("a_empty", 32'(a_empty), 32'(n <= 2));
    chk("a_full", 32'(a_full), 32'(n >= 14));
    chk("h_empty", 32'(h_empty), 32'(n < 8));
    chk("h_full", 32'(h_full), 32'(n >= 8));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
    chk("rd_valid", 32'(rd_valid), 32'(m_valid));
    chk("data_out", 32'(data_out), 32'(m_dout));
    if (rd_valid === 1'b1) begin
      if (sb.size() == 0) chk("sb_unexpected_pop", 32'(rd_valid), 32'(0));
      else chk("sb_data", 32'(data_out), 32'(sb.pop_front()));
    end
  endtask

  task automatic cycle_b(input bit w, input bit r, input logic [7:0] d);
    wr_en_b = w; rd_en_b = r; data_in = d; reset = 1'b1;
    wr_en = 0; rd_en = 0; err_clr = 0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 17; i++)
      vt[i] = '{1'b1, 1'b0, 8'(i + 1), (i < 16) ? i + 1 : 16,
                i >= 15, i >= 13, 1'b0, i == 16, 1'b0, 8'h00};
    for (int i = 0; i < 17; i++)
      vt[17 + i] = '{1'b0, 1'b1, 8'h00, (i < 16) ? 15 - i : 0,
                     1'b0, i <= 1, i >= 15, 1'b1, i == 16, (i < 16) ? 8'(i + 1) : 8'h10};

    // reset state
    cycle(0, 0, 0, 0, 8'h00);
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_a_full", 32'(a_full), 0);
    chk("rst_h_full", 32'(h_full), 0);

    // fill to overflow, then drain to underflow
    for (int k = 0; k < 34; k++) begin
      cycle(vt[k].wr, vt[k].rd, 0, 1, vt[k].din);
      chk($sformatf("tbl%0d_count", k), 32'(count), 32'(vt[k].cnt));
      chk($sformatf("tbl%0d_full", k), 32'(full), 32'(vt[k].full));
      chk($sformatf("tbl%0d_a_full", k), 32'(a_full), 32'(vt[k].af));
      chk($sformatf("tbl%0d_empty", k), 32'(empty), 32'(vt[k].empty));
      chk($sformatf("tbl%0d_overflow", k), 32'(overflow), 32'(vt[k].ovf));
      chk($sformatf("tbl%0d_underflow", k), 32'(underflow), 32'(vt[k].unf));
      chk($sformatf("tbl%0d_data_out", k), 32'(data_out), 32'(vt[k].dout));
    end
    cycle(0, 0, 0, 1, 8'h00);
    chk("hold_data_out", 32'(data_out), 32'h10);

    // simultaneous read/write at half occupancy across pointer wrap
    cycle(0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 8; i++) cycle(1, 0, 0, 1, 8'(8'h20 + i));
    for (int i = 0; i < 20; i++) begin
      cycle(1, 1, 0, 1, 8'(8'h40 + i));
      chk("wrap_count", 32'(count), 8);
    end
    for (int i = 0; i < 8; i++) cycle(0, 1, 0, 1, 8'h00);
    chk("wrap_last_word", 32'(data_out), 32'h53);
    chk("wrap_empty", 32'(empty), 1);

    // full with read+write, then clear; clear racing a new underflow
    cycle(0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 16; i++) cycle(1, 0, 0, 1, 8'(8'h80 + i));
    cycle(1, 1, 0, 1, 8'hEE);
    chk("full_rw_count", 32'(count), 15);
    chk("full_rw_overflow", 32'(overflow), 1);
    cycle(0, 0, 1, 1, 8'h00);
    chk("clr_overflow", 32'(overflow), 0);
    for (int i = 0; i < 15; i++) cycle(0, 1, 0, 1, 8'h00);
    cycle(0, 1, 1, 1, 8'h00);
    chk("clr_vs_new_underflow", 32'(underflow), 1);

    // reset mid-stream overrides everything
    cycle(0, 0, 0, 0, 8'h00);
    cycle(0, 1, 0, 1, 8'h00);
    for (int i = 0; i < 6; i++) cycle(1, 0, 0, 1, 8'(8'h60 + i));
    cycle(0, 1, 0, 1, 8'h00);
    chk("pre_rst_count", 32'(count), 5);
    chk("pre_rst_data", 32'(data_out), 32'h60);
    cycle(1, 1, 1, 0, 8'h77);
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_empty", 32'(empty), 1);
    chk("mid_rst_underflow", 32'(underflow), 0);
    chk("mid_rst_overflow", 32'(overflow), 0);
    chk("mid_rst_data_out", 32'(data_out), 0);

    // first-word-fall-through instance
    cycle(0, 0, 0, 0, 8'h00);
    chk("fwft_rst_valid", 32'(rd_valid_b), 0);
    cycle_b(1, 0, 8'hA5);
    wr_en_b = 0;
    chk("fwft_data_out", 32'(data_out_b), 32'hA5);
    chk("fwft_rd_valid", 32'(rd_valid_b), 1);
    chk("fwft_count", 32'(count_b), 1);
    cycle(0, 0, 0, 0, 8'h00);
    cycle_b(1, 1, 8'h3C);
    chk("fwft_wr_rd_empty_count", 32'(count_b), 1);
    chk("fwft_wr_rd_empty_underflow", 32'(underflow_b), 0);
    chk("fwft_wr_rd_empty_data", 32'(data_out_b), 32'h3C);
    cycle_b(0, 1, 8'h00);
    chk("fwft_drain_empty", 32'(empty_b), 1);
    chk("fwft_drain_valid", 32'(rd_valid_b), 0);
    cycle_b(0, 1, 8'h00);
    chk("fwft_underflow", 32'(underflow_b), 1);
    rd_en_b = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
